// File: rtl/seq_mult_8x8_if.sv
// Operand/result handshake bundle for the sequential 8x8 multiplier.
// The master issues start with operands; the slave returns the product and its status.
interface seq_mult_8x8_if;
   logic        start;
   logic [7:0]  A;
   logic [7:0]  B;
   logic [15:0] product;
   logic        busy;
   logic        done;

   modport master (output start, A, B, input product, busy, done);
   modport slave  (input start, A, B, output product, busy, done);
endinterface

// File: rtl/seq_mult_8x8.sv
// Unsigned 8x8 shift-and-add multiplier: one 8-bit cascaded CLA add per iteration,
// eight iterations, 16-bit registered product with a start/busy/done handshake.

// 8-bit adder built from two 4-bit carry-lookahead groups with the group carry cascaded.
module CASCADE (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       c_in,
   output logic [7:0] sum,
   output logic       cout
);
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      return {c[4], p ^ c[3:0]};
   endfunction

   logic [4:0] w_lo;
   logic [4:0] w_hi;

   assign w_lo = cla4(a[3:0], b[3:0], c_in);
   assign w_hi = cla4(a[7:4], b[7:4], w_lo[4]);
   assign sum  = {w_hi[3:0], w_lo[3:0]};
   assign cout = w_hi[4];
endmodule

// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// CALC  | eight add-and-shift iterations, busy high
// DONE  | one-cycle done pulse, product valid; start ignored
module seq_mult_8x8 (
   input  logic          clk,
   input  logic          rst,
   seq_mult_8x8_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_m;
   logic [7:0]  r_q;
   logic [7:0]  r_acc;
   logic [3:0]  r_cnt;
   logic [15:0] r_product;
   logic [7:0]  w_addend;
   logic [7:0]  w_sum;
   logic        w_cout;
   logic        w_busy;
   logic        w_done;

   assign w_addend = r_q[0] ? r_m : 8'h00;

   CASCADE u_add (
      .a    (r_acc),
      .b    (w_addend),
      .c_in (1'b0),
      .sum  (w_sum),
      .cout (w_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_CALC;
         S_CALC:  if (r_cnt == 4'd7) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_CALC:  w_busy = 1'b1;
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m       <= 8'h00;
         r_q       <= 8'h00;
         r_acc     <= 8'h00;
         r_cnt     <= 4'd0;
         r_product <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_m   <= bus.A;
                  r_q   <= bus.B;
                  r_acc <= 8'h00;
                  r_cnt <= 4'd0;
               end
            end
            S_CALC: begin
               // the adder carry-out becomes ACC[7] so no product bit is lost
               r_acc <= {w_cout, w_sum[7:1]};
               r_q   <= {w_sum[0], r_q[7:1]};
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == 4'd7) r_product <= {w_cout, w_sum, r_q[7:1]};
            end
            default: ;
         endcase
      end
   end

   assign bus.product = r_product;
   assign bus.busy    = w_busy;
   assign bus.done    = w_done;
endmodule

// File: tb/tb_seq_mult_8x8.sv
// Self-checking bench for seq_mult_8x8: directed vector table, handshake corner
// sequences and random back-to-back operations against a plain A*B reference.
module tb_seq_mult_8x8;
   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;

   logic        clk;
   logic        rst;
   int          total = 0;
   int          bad = 0;
   int          done_seen = 0;
   int          done_exp = 0;
   logic [15:0] prev_prod = 16'h0000;
   vec_t        vecs [5];

   seq_mult_8x8_if bus ();

   seq_mult_8x8 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // handshake invariants sampled every cycle away from the active edge
   always @(negedge clk) begin
      if (bus.done === 1'b1) done_seen++;
      total++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) begin
         bad++;
         $display("FAIL busy_done_overlap at %0t: busy=1 done=1", $time);
      end
      total++;
      if (rst !== 1'b1 && bus.done !== 1'b1 && bus.product !== prev_prod) begin
         bad++;
         $display("FAIL product_stable at %0t: got 0x%0h expected 0x%0h", $time, bus.product, prev_prod);
      end
      prev_prod = bus.product;
   end

   task automatic start_op(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = a;
      bus.B     = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.A     = 8'($urandom);
      bus.B     = 8'($urandom);
   endtask

   // called just after the accepting edge; done must appear on the 9th falling edge
   task automatic wait_done(input logic [15:0] exp, input string name);
      int  n = 0;
      int  nbusy = 0;
      bit  got = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.busy === 1'b1) nbusy++;
         if (bus.done === 1'b1) begin
            n   = i;
            got = 1;
            break;
         end
      end
      done_exp++;
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s timeout: no done within 20 cycles, expected product 0x%0h", name, exp);
      end else begin
         check({name, " latency"}, 32'(n), 32'd9);
         check({name, " busy_cycles"}, 32'(nbusy), 32'd8);
         check({name, " product"}, 32'(bus.product), 32'(exp));
      end
   endtask

   initial begin
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [15:0] rexp;
      int          d0;

      vecs[0] = '{a: 8'd3,   b: 8'd5,   p: 16'h000F};
      vecs[1] = '{a: 8'd141, b: 8'd138, p: 16'h4C02};
      vecs[2] = '{a: 8'hFF,  b: 8'hFF,  p: 16'hFE01};
      vecs[3] = '{a: 8'h00,  b: 8'hB7,  p: 16'h0000};
      vecs[4] = '{a: 8'h01,  b: 8'hC8,  p: 16'h00C8};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.A     = 8'h00;
      bus.B     = 8'h00;
      #3;
      check("reset product", 32'(bus.product), 32'h0);
      check("reset busy", 32'(bus.busy), 32'h0);
      check("reset done", 32'(bus.done), 32'h0);
      #9 rst = 1'b0;

      start_op(8'd141, 8'd138);
      wait_done(16'h4C02, "nominal");
      repeat (3) @(negedge clk);
      check("nominal hold", 32'(bus.product), 32'h4C02);

      // asynchronous reset between edges clears outputs immediately
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async rst product", 32'(bus.product), 32'h0);
      check("async rst busy", 32'(bus.busy), 32'h0);
      check("async rst done", 32'(bus.done), 32'h0);
      @(negedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         wait_done(vecs[i].p, $sformatf("vec%0d", i));
      end

      // start held and operands changed while busy: only the captured pair counts
      @(negedge clk);
      bus.start = 1'b1;
      bus.A     = 8'h0C;
      bus.B     = 8'h0D;
      @(posedge clk);
      #1;
      bus.A     = 8'hFF;
      bus.B     = 8'hFF;
      wait_done(16'h009C, "busy_protect");
      @(posedge clk);
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(16'hFE01, "after_protect");

      // reset mid-operation discards the op with no done pulse
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      #1 rst = 1'b0;
      start_op(8'h55, 8'h33);
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst product", 32'(bus.product), 32'h0);
      check("midrst busy", 32'(bus.busy), 32'h0);
      check("midrst done", 32'(bus.done), 32'h0);
      @(negedge clk);
      #1 rst = 1'b0;
      d0 = done_seen;
      repeat (12) @(negedge clk);
      check("midrst no_done", 32'(done_seen - d0), 32'h0);
      check("midrst product_after", 32'(bus.product), 32'h0);
      start_op(8'h10, 8'h10);
      wait_done(16'h0100, "after_midrst");

      for (int i = 0; i < 200; i++) begin
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rexp = 16'(int'(ra) * int'(rb));
         start_op(ra, rb);
         wait_done(rexp, $sformatf("rand%0d a=%0d b=%0d", i, ra, rb));
      end

      repeat (3) @(negedge clk);
      check("done pulse count", 32'(done_seen), 32'(done_exp));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seq_mult_8x8.md
# seq_mult_8x8

Sequential unsigned 8x8 shift-and-add multiplier producing a 16-bit product over eight iteration cycles. It is the first sequential consumer of the team's 8-bit adders. Each iteration drives one instance of the existing 8-bit cascaded CLA adder (`CASCADE`) with the accumulator and multiplicand, then registers the sum and carry-out. A start/done handshake lets a controller or testbench issue operands and collect the product.

## Interface
Parameters:
- none (width fixed at 8x8 -> 16, matching the existing 8-bit adder datapath)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  8  multiplicand, unsigned; captured on the accepted start edge
- B  input  8  multiplier, unsigned; captured on the accepted start edge
- product  output  16  result register; holds its last value until the next result is written
- busy  output  1  high while an operation is in progress (LOAD/CALC)
- done  output  1  one-cycle pulse; product valid from this cycle onward

## Operation
- Clock `clk`, reset `rst`. Reset is asynchronous and active-high, fixed as decided.
- Internal registers:
  - M[7:0]: multiplicand
  - Q[7:0]: multiplier, which becomes the product low half
  - ACC[7:0]: accumulator, the product high half
  - cnt[3:0]: iteration counter
  - state
- Adder usage: one CASCADE instance with inputs ACC, (Q[0] ? M : 8'h00), c_in=0, giving {cout,sum}.
- FSM states: IDLE, CALC, DONE.
  - IDLE: busy=0, done=0. When start=1 at a clock edge: M<=A, Q<=B, ACC<=0, cnt<=0, go to CALC.
  - CALC: busy=1. Each edge: {ACC,Q} <= {cout,sum,Q} >> 1, i.e. ACC<= {cout,sum[7:1]} and Q<={sum[0],Q[7:1]}. Also cnt<=cnt+1.
    - When cnt==7 on this edge, go to DONE and write product <= the post-shift {ACC,Q}.
  - DONE: done=1, busy=0. Next edge returns unconditionally to IDLE. start in DONE is ignored.
- start while busy (CALC) is ignored; M, Q and the sequence are unaffected.
- The operands A and B may change freely after the accepting edge.
- Arithmetic is unsigned and exact: product = A*B, 0..65025. Overflow is impossible. cout from the adder is never dropped, because it shifts into ACC[7].
- Reset behaviour, whether asserted in idle or mid-operation:
  - Immediately: state=IDLE, product=16'h0000, busy=0, done=0, M=Q=ACC=0, cnt=0.
  - The in-flight operation is discarded and no done is produced.
  - After release, the block is ready for start on the first edge.

## Timing
- Edge E0: start sampled in IDLE (load).
- Edges E1..E8: the eight CALC iterations. State is DONE after E8 and product is valid after E8.
- done is high for exactly one cycle, between E8 and E9. The block is back in IDLE after E9.
- Latency from the accepting edge to done rising is 8 clocks. Minimum start-to-start interval is 10 clocks; the earliest new start is sampled at E10.
- busy is high from after E0 until after E8, i.e. 8 cycles.
- product changes only at an E8 edge or on reset. Mid-operation partial values never appear on product.
- All outputs are registered or decoded directly from state. The adder path (ACC+M) must close within one clock.

## Test plan
- Reset: assert rst asynchronously between edges -> product=0x0000, busy=0, done=0 immediately. After release, start with A=3, B=5 -> done 8 clocks after the accepting edge, product=0x000F.
- Nominal: A=8'b10001101 (141), B=8'b10001010 (138), start one cycle -> busy for 8 cycles, single done pulse, product=0x4C02 (19458), held until the next result.
- Corners:
  - A=0xFF, B=0xFF -> product=0xFE01. This exercises cout into ACC[7].
  - A=0x00, B=0xB7 -> 0x0000.
  - A=0x01, B=0xC8 -> 0x00C8.
- Busy protection: start A=0x0C, B=0x0D. Hold start high and change A/B to 0xFF/0xFF during CALC and DONE -> product=0x009C. The next op is accepted at E10 and yields 0xFE01.
- Reset mid-op: start A=0x55, B=0x33. Assert rst after E4 -> no done pulse, product stays 0x0000. A fresh op A=0x10, B=0x10 -> 0x0100.
- Back-to-back random: 200 random A/B pairs issued at the earliest accepted start -> each product equals A*B. done pulses exactly once per accepted start, and busy is never high in the same cycle as done.
